// File: rtl/exacc_pkg.sv
// Shared types and constants for the external-access controller.
// Target indices follow the bit order of the per-target lock/strobe vectors.
package exacc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RBURST,
        WBURST,
        DRAIN
    } state_t;

    localparam int IMEM  = 0;
    localparam int LTBL  = 1;
    localparam int STBL  = 2;
    localparam int BANK  = 3;
    localparam int ACT   = 4;
    localparam int NET   = 5;
    localparam int CONST = 6;

    // Select field sits in the top SEL_W bits of the host address.
    localparam int ADR_W_DEF   = 16;
    localparam int SEL_W_DEF   = 3;
    localparam int SEL_MSB_DEF = ADR_W_DEF - 1;
    localparam int SEL_LSB_DEF = ADR_W_DEF - SEL_W_DEF;

    function automatic int sel_lsb(input int adr_w, input int sel_w);
        return adr_w - sel_w;
    endfunction

endpackage

// File: rtl/exacc_rdpipe.sv
// Read-return pipeline: carries {valid, err, target index} for each read beat
// so the returning data can be picked from the right target RD_LAT cycles later.
module exacc_rdpipe
    import exacc_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic             push_err,
    input  logic [SEL_W-1:0] push_tgt,
    output logic             tap_valid,
    output logic             tap_err,
    output logic [SEL_W-1:0] tap_tgt,
    output logic             out_valid,
    output logic             out_err,
    output logic             pend
);

    logic [RD_LAT:0]  valid_sr;
    logic [RD_LAT:0]  err_sr;
    logic [SEL_W-1:0] tgt_sr [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            err_sr   <= '0;
            for (int i = 0; i < RD_LAT; i++) tgt_sr[i] <= '0;
        end else begin
            valid_sr <= {valid_sr[RD_LAT-1:0], push_valid};
            err_sr   <= {err_sr[RD_LAT-1:0], push_err};
            tgt_sr[0] <= push_tgt;
            for (int i = 1; i < RD_LAT; i++) tgt_sr[i] <= tgt_sr[i-1];
        end
    end

    // Tap stage: target data is valid now and gets registered into o_rd.
    assign tap_valid = valid_sr[RD_LAT-1];
    assign tap_err   = err_sr[RD_LAT-1];
    assign tap_tgt   = tgt_sr[RD_LAT-1];
    assign out_valid = valid_sr[RD_LAT];
    assign out_err   = err_sr[RD_LAT];

    // Beats still upstream of the tap; once clear, the last beat is already at the tap.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) pend = pend | valid_sr[i];
    end

endmodule

// File: rtl/ex_acc_ctrl.sv
// External-access controller: host request handshake, per-target strobes, locks
// and latency-matched read return. Bursts are built only with EXACC_BURST_EN.
//
// state  | meaning
// IDLE   | ready for a host request
// ISSUE  | first (or only) beat strobed from the latched request
// RBURST | one read beat per cycle, local address incrementing
// WBURST | one write beat per accepted host beat
// DRAIN  | waiting for read returns to leave the pipeline
module ex_acc_ctrl
    import exacc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADR_W  = ADR_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int N_TGT  = 7,
    parameter int RD_LAT = 1,
    parameter int BLEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    output logic                    o_ready,
    input  logic                    i_we,
    input  logic [ADR_W-1:0]        i_adr,
    input  logic [DATA_W-1:0]       i_wd,
    input  logic [BLEN_W-1:0]       i_blen,
    output logic                    o_rvalid,
    output logic [DATA_W-1:0]       o_rd,
    output logic                    o_err,
    input  logic [N_TGT-1:0]        i_lock,
    output logic [N_TGT-1:0]        o_tgt_we,
    output logic [N_TGT-1:0]        o_tgt_re,
    output logic [ADR_W-SEL_W-1:0]  o_tgt_a,
    output logic [DATA_W-1:0]       o_tgt_wd,
    input  logic [N_TGT*DATA_W-1:0] i_tgt_rd
);

    localparam int LA_W = ADR_W - SEL_W;

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [LA_W-1:0]   la_q;
    logic [DATA_W-1:0] wd_q;
    logic              werr_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_nxt;

    logic              beat;
    logic              beat_we;
    logic              wbeat;
    logic              fault;
    logic              sel_ok;
    logic              lock_hit;
    logic [N_TGT-1:0]  sel_hot;
    logic              burst_go;
    logic              last_beat;

    logic              tap_valid;
    logic              tap_err;
    logic [SEL_W-1:0]  tap_tgt;
    logic              out_valid;
    logic              out_err;
    logic              pend;

`ifdef EXACC_BURST_EN
    logic [BLEN_W-1:0] cnt;

    assign burst_go  = (cnt != '0);
    assign last_beat = (cnt == BLEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE && i_req) begin
            cnt <= i_blen;
        end else if (beat && state != ISSUE) begin
            cnt <= cnt - BLEN_W'(1);
        end
    end
`else
    logic [BLEN_W-1:0] unused_blen;

    assign unused_blen = i_blen;
    assign burst_go    = 1'b0;
    assign last_beat   = 1'b1;
`endif

    always_comb begin
        sel_hot  = '0;
        sel_ok   = 1'b0;
        lock_hit = 1'b0;
        for (int t = 0; t < N_TGT; t++) begin
            if (sel_q == SEL_W'(t)) begin
                sel_hot[t] = 1'b1;
                sel_ok     = 1'b1;
                lock_hit   = i_lock[t];
            end
        end
    end

    // Lock is sampled per beat, so a mid-burst change only hits later beats.
    assign fault   = !sel_ok || lock_hit;
    assign wbeat   = (state == WBURST) && i_req && i_we;
    assign beat    = (state == ISSUE) || (state == RBURST) || wbeat;
    assign beat_we = (state == WBURST) || ((state == ISSUE) && we_q);

    assign o_ready  = rst_n && ((state == IDLE) || (state == WBURST));
    assign o_tgt_we = (beat && beat_we && !fault) ? sel_hot : '0;
    assign o_tgt_re = (beat && !beat_we && !fault) ? sel_hot : '0;
    assign o_tgt_a  = la_q;
    assign o_tgt_wd = (state == WBURST) ? i_wd : wd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req) state_nxt = ISSUE;
            ISSUE: begin
                if (burst_go) state_nxt = we_q ? WBURST : RBURST;
                else          state_nxt = we_q ? IDLE : DRAIN;
            end
            RBURST:  if (last_beat) state_nxt = DRAIN;
            WBURST:  if (wbeat && last_beat) state_nxt = IDLE;
            DRAIN:   if (!pend) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            sel_q  <= '0;
            la_q   <= '0;
            wd_q   <= '0;
            werr_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            werr_q <= beat && beat_we && fault;
            rd_q   <= rd_nxt;
            if (state == IDLE && i_req) begin
                we_q  <= i_we;
                sel_q <= i_adr[ADR_W-1 -: SEL_W];
                la_q  <= i_adr[LA_W-1:0];
                wd_q  <= i_wd;
            end else if (beat) begin
                la_q <= la_q + LA_W'(1);
            end
        end
    end

    exacc_rdpipe #(
        .RD_LAT (RD_LAT),
        .SEL_W  (SEL_W)
    ) u_rdpipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (beat && !beat_we),
        .push_err   (fault),
        .push_tgt   (sel_q),
        .tap_valid  (tap_valid),
        .tap_err    (tap_err),
        .tap_tgt    (tap_tgt),
        .out_valid  (out_valid),
        .out_err    (out_err),
        .pend       (pend)
    );

    // Faulted reads return zero data alongside o_err.
    always_comb begin
        rd_nxt = '0;
        if (tap_valid && !tap_err) begin
            for (int t = 0; t < N_TGT; t++) begin
                if (tap_tgt == SEL_W'(t)) rd_nxt = i_tgt_rd[t*DATA_W +: DATA_W];
            end
        end
    end

    assign o_rvalid = out_valid;
    assign o_rd     = rd_q;
    assign o_err    = (out_valid && out_err) || werr_q;

endmodule

// File: tb/tb_ex_acc_ctrl.sv
// Scoreboard bench for ex_acc_ctrl: stimulus pushes expected strobes, read
// returns and write-error pulses; a negedge monitor pops and compares them.
module tb_ex_acc_ctrl;
    import exacc_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADR_W  = 16;
    localparam int SEL_W  = 3;
    localparam int N_TGT  = 7;
    localparam int RD_LAT = 1;
    localparam int BLEN_W = 8;
    localparam int LA_W   = ADR_W - SEL_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    i_req;
    logic                    o_ready;
    logic                    i_we;
    logic [ADR_W-1:0]        i_adr;
    logic [DATA_W-1:0]       i_wd;
    logic [BLEN_W-1:0]       i_blen;
    logic                    o_rvalid;
    logic [DATA_W-1:0]       o_rd;
    logic                    o_err;
    logic [N_TGT-1:0]        i_lock;
    logic [N_TGT-1:0]        o_tgt_we;
    logic [N_TGT-1:0]        o_tgt_re;
    logic [LA_W-1:0]         o_tgt_a;
    logic [DATA_W-1:0]       o_tgt_wd;
    logic [N_TGT*DATA_W-1:0] i_tgt_rd;

    ex_acc_ctrl #(
        .DATA_W (DATA_W), .ADR_W (ADR_W), .SEL_W (SEL_W),
        .N_TGT (N_TGT), .RD_LAT (RD_LAT), .BLEN_W (BLEN_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_req (i_req), .o_ready (o_ready),
        .i_we (i_we), .i_adr (i_adr), .i_wd (i_wd), .i_blen (i_blen),
        .o_rvalid (o_rvalid), .o_rd (o_rd), .o_err (o_err), .i_lock (i_lock),
        .o_tgt_we (o_tgt_we), .o_tgt_re (o_tgt_re), .o_tgt_a (o_tgt_a),
        .o_tgt_wd (o_tgt_wd), .i_tgt_rd (i_tgt_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: one registered-read memory per target; unwritten words
    // read back as A00t_aaaa.
    logic [DATA_W-1:0] mem     [N_TGT][1 << LA_W];
    bit                written [N_TGT][1 << LA_W];

    function automatic logic [DATA_W-1:0] pat(input int t, input logic [LA_W-1:0] a);
        return 32'hA000_0000 | (32'(t) << 16) | 32'(a);
    endfunction

    always @(posedge clk) begin
        for (int t = 0; t < N_TGT; t++) begin
            if (o_tgt_we[t]) begin
                mem[t][o_tgt_a]     <= o_tgt_wd;
                written[t][o_tgt_a] <= 1'b1;
            end
            if (o_tgt_re[t])
                i_tgt_rd[t*DATA_W +: DATA_W] <= written[t][o_tgt_a] ? mem[t][o_tgt_a] : pat(t, o_tgt_a);
        end
    end

    typedef struct {
        logic [N_TGT-1:0]  we;
        logic [N_TGT-1:0]  re;
        logic [LA_W-1:0]   a;
        logic [DATA_W-1:0] wd;
        int                cyc;
    } strb_t;

    typedef struct {
        logic [DATA_W-1:0] rd;
        logic              err;
        int                cyc;
    } rd_t;

    strb_t sq[$];
    rd_t   rq[$];
    int    wq[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string info);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, info, cyc);
    endtask

    strb_t s;
    rd_t   r;

    always @(negedge clk) begin
        if (mon_en) begin
            if ((o_tgt_we | o_tgt_re) != '0) begin
                if (sq.size() == 0) begin
                    fail("spurious_strobe", $sformatf("we=%b re=%b a=%0h", o_tgt_we, o_tgt_re, o_tgt_a));
                end else begin
                    s = sq.pop_front();
                    chk("strobe_we", o_tgt_we, s.we);
                    chk("strobe_re", o_tgt_re, s.re);
                    chk("strobe_adr", o_tgt_a, s.a);
                    if (s.we != '0) chk("strobe_wd", o_tgt_wd, s.wd);
                    chk("strobe_cycle", cyc, s.cyc);
                end
            end
            if (o_rvalid) begin
                if (rq.size() == 0) begin
                    fail("spurious_rvalid", $sformatf("rd=%0h err=%b", o_rd, o_err));
                end else begin
                    r = rq.pop_front();
                    chk("rd_data", o_rd, r.rd);
                    chk("rd_err", o_err, r.err);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end else if (o_err) begin
                if (wq.size() == 0) fail("spurious_err", "o_err without pending write fault");
                else chk("werr_cycle", cyc, wq.pop_front());
            end
        end
    end

    // Presents one request; k returns the accepting edge, and the task returns
    // one step into the cycle that follows it.
    task automatic req(input logic we, input logic [ADR_W-1:0] adr, input logic [DATA_W-1:0] wd,
                       input logic [BLEN_W-1:0] blen, output int k);
        int n = 0;
        @(posedge clk); #1;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) fail("ready_timeout", "o_ready never rose");
        i_req  = 1'b1;
        i_we   = we;
        i_adr  = adr;
        i_wd   = wd;
        i_blen = blen;
        k = cyc + 1;
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (n < 50 && !(o_ready && sq.size() == 0 && rq.size() == 0 && wq.size() == 0));
        if (!(o_ready && sq.size() == 0 && rq.size() == 0 && wq.size() == 0))
            fail("idle_timeout", $sformatf("sq=%0d rq=%0d wq=%0d", sq.size(), rq.size(), wq.size()));
    endtask

    function automatic void exp_strb(input logic [N_TGT-1:0] we, input logic [N_TGT-1:0] re,
                                     input logic [LA_W-1:0] a, input logic [DATA_W-1:0] wd, input int c);
        strb_t e;
        e.we = we; e.re = re; e.a = a; e.wd = wd; e.cyc = c;
        sq.push_back(e);
    endfunction

    function automatic void exp_rd(input logic [DATA_W-1:0] d, input logic err, input int c);
        rd_t e;
        e.rd = d; e.err = err; e.cyc = c;
        rq.push_back(e);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [LA_W-1:0]   ba [4];
        logic [DATA_W-1:0] bd [4];

        i_req = 1'b0; i_we = 1'b0; i_adr = '0; i_wd = '0; i_blen = '0; i_lock = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_ready", o_ready, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_strobes", {o_tgt_we, o_tgt_re}, 0);
        chk("rst_adr", o_tgt_a, 0);
        chk("rst_wd", o_tgt_wd, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rel_ready", o_ready, 1);

        // Reset in the middle of a 16-beat read burst to BANK.
        req(1'b0, 16'h6200, '0, 8'd15, k);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", o_ready, 0);
        chk("midrst_rvalid", o_rvalid, 0);
        chk("midrst_strobes", {o_tgt_we, o_tgt_re}, 0);
        chk("midrst_adr", o_tgt_a, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_rvalid", o_rvalid, 0);
            chk("postrst_strobes", {o_tgt_we, o_tgt_re}, 0);
            chk("postrst_ready", o_ready, 1);
        end
        mon_en = 1'b1;

        // Write then read back BANK, local 0x1010.
        req(1'b1, 16'h7010, 32'h1234_5678, 8'd0, k);
        exp_strb(7'b0001000, 7'b0, 13'h1010, 32'h1234_5678, k);
        chk("wr_ready_issue", o_ready, 0);
        @(posedge clk); #1;
        chk("wr_ready_back", o_ready, 1);
        wait_idle();

        req(1'b0, 16'h7010, '0, 8'd0, k);
        exp_strb(7'b0, 7'b0001000, 13'h1010, '0, k);
        exp_rd(32'h1234_5678, 1'b0, k + 2);
        chk("rd_ready_issue", o_ready, 0);
        @(posedge clk); #1;
        chk("rd_ready_drain", o_ready, 0);
        @(posedge clk); #1;
        chk("rd_ready_back", o_ready, 1);
        wait_idle();

        // Unimplemented select value 7.
        req(1'b0, 16'hE000, '0, 8'd0, k);
        exp_rd(32'h0, 1'b1, k + 2);
        wait_idle();

        // Locked IMEM write faults; LTBL write goes through.
        i_lock = 7'b0000001;
        req(1'b1, 16'h0040, 32'hDEAD_BEEF, 8'd0, k);
        wq.push_back(k + 1);
        wait_idle();
        req(1'b1, 16'h2040, 32'hCAFE_F00D, 8'd0, k);
        exp_strb(7'b0000010, 7'b0, 13'h0040, 32'hCAFE_F00D, k);
        wait_idle();
        i_lock = 7'b0;
        req(1'b0, 16'h0040, '0, 8'd0, k);
        exp_strb(7'b0, 7'b0000001, 13'h0040, '0, k);
        exp_rd(32'hA000_0040, 1'b0, k + 2);
        wait_idle();
        req(1'b0, 16'h2040, '0, 8'd0, k);
        exp_strb(7'b0, 7'b0000010, 13'h0040, '0, k);
        exp_rd(32'hCAFE_F00D, 1'b0, k + 2);
        wait_idle();

        // Locked STBL read returns an error beat.
        i_lock = 7'b0000100;
        req(1'b0, 16'h4005, '0, 8'd0, k);
        exp_rd(32'h0, 1'b1, k + 2);
        wait_idle();
        i_lock = 7'b0;

        // Plain read of CONST, local 0x0123.
        req(1'b0, 16'hC123, '0, 8'd0, k);
        exp_strb(7'b0, 7'b1000000, 13'h0123, '0, k);
        exp_rd(32'hA006_0123, 1'b0, k + 2);
        wait_idle();

`ifdef EXACC_BURST_EN
        // 4-beat read burst wrapping the local address space.
        ba = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        bd = '{32'hA003_1FFE, 32'hA003_1FFF, 32'hA003_0000, 32'hA003_0001};
        req(1'b0, 16'h7FFE, '0, 8'd3, k);
        for (int b = 0; b < 4; b++) begin
            exp_strb(7'b0, 7'b0001000, ba[b], '0, k + b);
            exp_rd(bd[b], 1'b0, k + 2 + b);
        end
        wait_idle();

        // 3-beat write burst to NET with a gap (and a held-off read) before beat 2.
        req(1'b1, 16'hA100, 32'h1111_0000, 8'd2, k);
        exp_strb(7'b0100000, 7'b0, 13'h0100, 32'h1111_0000, k);
        @(posedge clk); #1;
        i_req = 1'b1; i_we = 1'b1; i_adr = 16'hFFFF; i_wd = 32'h1111_0001;
        exp_strb(7'b0100000, 7'b0, 13'h0101, 32'h1111_0001, k + 1);
        chk("wb_ready_beat1", o_ready, 1);
        @(posedge clk); #1;
        i_req = 1'b1; i_we = 1'b0;
        chk("wb_ready_gap", o_ready, 1);
        @(posedge clk); #1;
        i_req = 1'b1; i_we = 1'b1; i_wd = 32'h1111_0002;
        exp_strb(7'b0100000, 7'b0, 13'h0102, 32'h1111_0002, k + 3);
        @(posedge clk); #1;
        i_req = 1'b0;
        chk("wb_ready_idle", o_ready, 1);
        wait_idle();
        req(1'b0, 16'hA101, '0, 8'd0, k);
        exp_strb(7'b0, 7'b0100000, 13'h0101, '0, k);
        exp_rd(32'h1111_0001, 1'b0, k + 2);
        wait_idle();
        req(1'b0, 16'hA102, '0, 8'd0, k);
        exp_strb(7'b0, 7'b0100000, 13'h0102, '0, k);
        exp_rd(32'h1111_0002, 1'b0, k + 2);
        wait_idle();
`else
        ba = '{13'h0, 13'h0, 13'h0, 13'h0};
        bd = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif

        repeat (4) @(posedge clk);
        chk("strobe_q_empty", sq.size(), 0);
        chk("rd_q_empty", rq.size(), 0);
        chk("werr_q_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
